edge_capture_ctrl: RTL
======================

# edge_capture_ctrl

Parametrised multi-channel edge capture unit. Each channel detects rising, falling or both edges on an optionally synchronised and glitch-filtered input. Detected edges are latched into a sticky capture register with per-channel overflow flags, write-1-to-clear, and a maskable interrupt. It sits between raw asynchronous event inputs (buttons, external strobes, peripheral flags) and the register/interrupt fabric.

## Interface

Parameters:
- WIDTH, 32, number of channels.
- SYNC_STAGES, 2, input synchroniser flops per channel; 0 = inputs already synchronous (no stages).
- FILTER, 0, glitch-filter length in cycles; 0 = bypass.

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in  in  WIDTH  raw event inputs.
- mode  in  2*WIDTH  per-channel mode, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- clr  in  WIDTH  write-1-to-clear strobe for cap[i] and ovf[i].
- irq_en  in  WIDTH  per-channel interrupt enable.
- cap  out  WIDTH  sticky capture flags.
- ovf  out  WIDTH  sticky overflow flags: edge arrived while cap[i] already set.
- evt  out  WIDTH  one-cycle pulse per detected edge.
- irq  out  1  registered OR of (cap & irq_en).

## Operation

- Per-channel pipeline: in → SYNC_STAGES flops → filter → level; a level_prev register holds the previous level.
- Filter (FILTER=F≥1): the filtered level register takes the synced value on the F-th consecutive clock edge at which synced ≠ filtered. Any edge with synced = filtered resets the channel counter to 0. Counter width is clog2(F+1).
- Edge detect: rise = level & ~level_prev; fall = ~level & level_prev. The edge qualifies per mode[i]. Mode 00 blocks set and evt but does not clear existing flags.
- Per-channel update each cycle:
  - If edge: cap←1 and evt←1.
  - If edge and cap=1 and not clr: ovf←1.
  - If clr and no edge: cap←0.
  - If clr: ovf←0.
  - Priority: set of cap wins over clr; clr wins over ovf set.
- Priming: after reset release, a counter blocks edge qualification for SYNC_STAGES+FILTER+1 cycles. This stops static input levels present at reset from reporting edges. Priming is global, not per channel.
- Mode changes take effect on the edge evaluated in the same cycle. Captured state is untouched.
- irq ← |(cap & irq_en), registered. Clearing irq_en deasserts irq on the next edge.

## Timing

- Reset (reset_n=0, asynchronous, no clock needed):
  - cap, ovf, evt, irq = 0.
  - Sync, filter, level_prev and counters = 0.
  - Priming counter reloaded.
- Let k be the first clock edge sampling a new value of in[i]. Then cap[i] and evt[i] update at edge k+SYNC_STAGES+FILTER.
  - SYNC_STAGES=0, FILTER=0: update at edge k, the same cycle in is sampled.
- evt[i] is high for exactly one cycle per qualified edge. Back-to-back edges at the post-filter level produce consecutive evt pulses.
- irq follows cap by one cycle (edge k+S+F+1). It deasserts one cycle after the last enabled cap bit clears.
- clr acts at the edge where it is sampled. Holding clr high keeps clearing every cycle; a simultaneous edge still sets cap.
- Filter boundary: a pulse of exactly F cycles passes; a pulse of F−1 cycles is fully suppressed and never changes level.
- Reset asserted mid-filter or mid-priming discards all partial state.

## Test plan

- Priming: reset with in=32'hFFFF_FFFF, mode all 11, release and hold 10 cycles → cap=0, evt=0, irq=0 throughout.
- Fall mode (defaults): mode[1:0]=10, irq_en[0]=1. Drop in[0] 1→0 sampled at edge k → evt[0]=1 only in the cycle after edge k+2, cap[0]=1 from k+2, irq=1 from k+3. A later 0→1 on in[0] → no evt, cap unchanged.
- Both mode, overflow: mode ch5=11, in[5] high for 4 cycles → two evt[5] pulses 4 cycles apart; cap[5]=1; ovf[5]=1 after the second edge.
- Clear collision: with cap[5]=ovf[5]=1, pulse clr[5] on the same cycle an edge qualifies → cap[5]=1, ovf[5]=0. clr[5] alone next cycle → cap[5]=0, irq drops one cycle later.
- Filter (FILTER=3, SYNC_STAGES=2), mode 01:
  - 2-cycle high glitch → no evt, cap=0.
  - 3-cycle high pulse sampled from edge k → cap set at edge k+5.
- Async reset: assert reset_n=0 between clock edges with cap, ovf and irq set → all outputs 0 immediately. After release, priming repeats.

Source files
------------

// File: rtl/edge_capture_ctrl.sv
// edge_capture_ctrl: multi-channel edge capture with optional synchroniser and glitch filter,
// sticky capture/overflow flags, write-1-to-clear and a maskable registered interrupt.
module edge_capture_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in,
    input  logic [2*WIDTH-1:0]   mode,
    input  logic [WIDTH-1:0]     clr,
    input  logic [WIDTH-1:0]     irq_en,
    output logic [WIDTH-1:0]     cap,
    output logic [WIDTH-1:0]     ovf,
    output logic [WIDTH-1:0]     evt,
    output logic                 irq
);

    localparam int PRIME = SYNC_STAGES + FILTER + 1;
    localparam int PW    = $clog2(PRIME + 1);

    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] level_prev_q;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] evt_q, evt_d;
    logic             irq_q, irq_d;
    logic [PW-1:0]    prime_q, prime_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign synced = in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
            always_comb begin
                sync_d[0] = in;
                for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sync_d;
            end
            assign synced = sync_q[SYNC_STAGES-1];
        end

        if (FILTER == 0) begin : g_nofilt
            assign level = synced;
        end else begin : g_filt
            localparam int CW = $clog2(FILTER + 1);
            logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
            logic [WIDTH-1:0]         filt_q, filt_d;
            // The filtered level flips on the FILTER-th consecutive disagreeing edge.
            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i]  = (synced[i] == filt_q[i] || cnt_q[i] == CW'(FILTER - 1)) ? '0 : cnt_q[i] + CW'(1);
                    filt_d[i] = (synced[i] != filt_q[i] && cnt_q[i] == CW'(FILTER - 1)) ? synced[i] : filt_q[i];
                end
            end
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    filt_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end
            assign level = filt_q;
        end
    endgenerate

    // Edges are ignored until the pipeline has flushed the levels present at reset.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rise_en[i] = mode[2*i];
            fall_en[i] = mode[2*i+1];
        end
        hit     = (prime_q == '0) ? ((level & ~level_prev_q & rise_en) | (~level & level_prev_q & fall_en)) : '0;
        cap_d   = hit | (cap_q & ~clr);
        ovf_d   = ~clr & (ovf_q | (hit & cap_q));
        evt_d   = hit;
        irq_d   = |(cap_q & irq_en);
        prime_d = (prime_q == '0) ? prime_q : prime_q - PW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_prev_q <= '0;
            cap_q        <= '0;
            ovf_q        <= '0;
            evt_q        <= '0;
            irq_q        <= 1'b0;
            prime_q      <= PW'(PRIME);
        end else begin
            level_prev_q <= level;
            cap_q        <= cap_d;
            ovf_q        <= ovf_d;
            evt_q        <= evt_d;
            irq_q        <= irq_d;
            prime_q      <= prime_d;
        end
    end

    assign cap = cap_q;
    assign ovf = ovf_q;
    assign evt = evt_q;
    assign irq = irq_q;

endmodule
